// File: rtl/alu_pkg.sv
// Shared types and widths for the 8-bit ALU datapath.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int RES_W  = 9;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MUL  = 4'h2,
    OP_DIV  = 4'h3,
    OP_SHL  = 4'h4,
    OP_SHR  = 4'h5,
    OP_ROL  = 4'h6,
    OP_ROR  = 4'h7,
    OP_AND  = 4'h8,
    OP_OR   = 4'h9,
    OP_XOR  = 4'hA,
    OP_NOR  = 4'hB,
    OP_NAND = 4'hC,
    OP_XNOR = 4'hD,
    OP_GT   = 4'hE,
    OP_EQ   = 4'hF
  } alu_op_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_e           op;
  } alu_req_t;

endpackage

// File: rtl/alu_comb.sv
// Combinational opcode decode and datapath; bit 8 carries carry/borrow/shift-out/div-by-zero.
module alu_comb
  import alu_pkg::*;
(
  input  alu_req_t         req,
  output logic [RES_W-1:0] res
);

  logic [2*DATA_W-1:0] prod;
  logic [RES_W-1:0]    a_x, b_x;
  logic [DATA_W-1:0]   a, b;

  assign a    = req.a;
  assign b    = req.b;
  assign a_x  = {1'b0, a};
  assign b_x  = {1'b0, b};
  assign prod = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};

  always_comb begin
    res = '0;
    unique case (req.op)
      OP_ADD:  res = a_x + b_x;
      // 9-bit wrap makes bit 8 the borrow
      OP_SUB:  res = a_x - b_x;
      OP_MUL:  res = prod[RES_W-1:0];
      OP_DIV:  res = (b == '0) ? {RES_W{1'b1}} : {1'b0, a / b};
      OP_SHL:  res = {a, 1'b0};
      OP_SHR:  res = {2'b00, a[DATA_W-1:1]};
      OP_ROL:  res = {1'b0, a[DATA_W-2:0], a[DATA_W-1]};
      OP_ROR:  res = {1'b0, a[0], a[DATA_W-1:1]};
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      OP_XOR:  res = {1'b0, a ^ b};
      OP_NOR:  res = {1'b0, ~(a | b)};
      OP_NAND: res = {1'b0, ~(a & b)};
      OP_XNOR: res = {1'b0, ~(a ^ b)};
      OP_GT:   res = {{(RES_W-1){1'b0}}, (a > b)};
      OP_EQ:   res = {{(RES_W-1){1'b0}}, (a == b)};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/alu.sv
// 8-bit ALU top: combinational datapath followed by a single async-reset result register.
module alu
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        ALU_Sel,
  output logic [RES_W-1:0]  ALU_Result
);

  alu_req_t         req;
  logic [RES_W-1:0] res_nxt;

  assign req.a  = A;
  assign req.b  = B;
  assign req.op = alu_op_e'(ALU_Sel);

  alu_comb u_comb (
    .req (req),
    .res (res_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ALU_Result <= '0;
    else     ALU_Result <= res_nxt;
  end

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: stimulus pushes expected results, a monitor pops one per clock.
module tb_alu;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] A = 8'h00;
  logic [7:0] B = 8'h00;
  logic [3:0] ALU_Sel = 4'h0;
  logic [8:0] ALU_Result;

  typedef struct {
    logic [8:0] exp;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  alu dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .ALU_Sel    (ALU_Sel),
    .ALU_Result (ALU_Result)
  );

  always #5 clk = clk_en ? ~clk : clk;

  // Independent arithmetic reference built from integer math
  function automatic logic [8:0] ref_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      4'h0: r = ai + bi;
      4'h1: r = (ai - bi + 512) % 512;
      4'h2: r = (ai * bi) % 512;
      4'h3: r = (bi == 0) ? 511 : ai / bi;
      4'h4: r = (ai * 2) % 512;
      4'h5: r = ai / 2;
      4'h6: r = ((ai * 2) % 256) + ai / 128;
      4'h7: r = ai / 2 + (ai % 2) * 128;
      4'h8: r = int'(a & b);
      4'h9: r = int'(a | b);
      4'hA: r = int'(a ^ b);
      4'hB: r = 255 - int'(a | b);
      4'hC: r = 255 - int'(a & b);
      4'hD: r = 255 - int'(a ^ b);
      4'hE: r = (ai > bi) ? 1 : 0;
      default: r = (ai == bi) ? 1 : 0;
    endcase
    return 9'(r);
  endfunction

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                       input logic [8:0] exp, input string name);
    exp_t e;
    @(negedge clk);
    A = a;
    B = b;
    ALU_Sel = op;
    e.exp = exp;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic check_now(input logic [8:0] exp, input string name);
    checks++;
    if (ALU_Result !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, ALU_Result, exp);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (ALU_Result !== e.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", e.name, ALU_Result, e.exp);
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;

    // Async reset with non-zero inputs and no clock running
    A = 8'h12; B = 8'h34; ALU_Sel = 4'h0;
    #2 rst = 1'b1;
    #1 check_now(9'h000, "reset_async");
    #5 clk_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    issue(8'd3,   8'd4,   4'h0, 9'd7,   "add_3_4");
    issue(8'd255, 8'd0,   4'h0, 9'd255, "add_255_0");
    issue(8'd240, 8'd15,  4'h0, 9'd255, "add_240_15");
    issue(8'd255, 8'd255, 4'h0, 9'h1FE, "add_255_255");
    issue(8'd10,  8'd3,   4'h1, 9'd7,   "sub_10_3");
    issue(8'd3,   8'd10,  4'h1, 9'h1F9, "sub_3_10");
    issue(8'd16,  8'd16,  4'h2, 9'h100, "mul_16_16");
    issue(8'd255, 8'd255, 4'h2, 9'h001, "mul_255_255");
    issue(8'd200, 8'd7,   4'h3, 9'd28,  "div_200_7");
    issue(8'd5,   8'd0,   4'h3, 9'h1FF, "div_5_0");
    issue(8'h81,  8'hFF,  4'h4, 9'h102, "shl_81");
    issue(8'h81,  8'hFF,  4'h5, 9'h040, "shr_81");
    issue(8'h81,  8'h00,  4'h6, 9'h003, "rol_81");
    issue(8'h81,  8'h00,  4'h7, 9'h0C0, "ror_81");
    issue(8'hF0,  8'h3C,  4'h8, 9'h030, "and");
    issue(8'hF0,  8'h3C,  4'h9, 9'h0FC, "or");
    issue(8'hF0,  8'h3C,  4'hA, 9'h0CC, "xor");
    issue(8'hF0,  8'h3C,  4'hB, 9'h003, "nor");
    issue(8'hF0,  8'h3C,  4'hC, 9'h0CF, "nand");
    issue(8'hF0,  8'h3C,  4'hD, 9'h033, "xnor");
    issue(8'hF0,  8'h3C,  4'hE, 9'h001, "gt_f0_3c");
    issue(8'h3C,  8'hF0,  4'hE, 9'h000, "gt_3c_f0");
    issue(8'd5,   8'd5,   4'hF, 9'h001, "eq_5_5");
    issue(8'd5,   8'd6,   4'hF, 9'h000, "eq_5_6");

    // Back-to-back over every opcode with random operands
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      issue(ra, rb, 4'(i), ref_f(ra, rb, 4'(i)), $sformatf("b2b_op%0d_%h_%h", i, ra, rb));
    end
    for (int i = 0; i < 16; i++) begin
      ra = 8'($urandom);
      rb = (i == 3) ? 8'h00 : 8'($urandom);
      issue(ra, rb, 4'(15 - i), ref_f(ra, rb, 4'(15 - i)), $sformatf("b2b_rev_op%0d_%h_%h", 15 - i, ra, rb));
    end

    // Mid-stream reset clears between edges
    issue(8'd100, 8'd100, 4'h0, 9'd200, "add_pre_reset");
    @(negedge clk);
    A = 8'hAA; B = 8'h55; ALU_Sel = 4'h9;
    #1 rst = 1'b1;
    #1 check_now(9'h000, "reset_midstream");
    @(negedge clk);
    check_now(9'h000, "reset_held");
    rst = 1'b0;
    issue(8'd1, 8'd2, 4'h0, 9'd3, "add_post_reset");

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu.md
Name: alu

Overview:
- 8-bit arithmetic/logic unit with 16 operations chosen by a 4-bit opcode.
- Produces a 9-bit result; bit 8 carries carry/borrow/shift-out or an error flag, depending on the operation.
- The result is registered: one clock, asynchronous active-high reset.
- Used as a datapath leaf block; it has no handshake and accepts a new operation every cycle.

Parameters:
- None. Operand width is fixed at 8 and result width at 9.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- A  input  8  operand A, unsigned
- B  input  8  operand B, unsigned
- ALU_Sel  input  4  opcode
- ALU_Result  output  9  registered result

Behaviour:
- Reset: while rst is high, ALU_Result = 9'h000 immediately, with no clock needed. The first capture happens at the first rising clk edge after rst deasserts.
- Latency: 1 cycle. On each rising clk edge, ALU_Result <= f(A, B, ALU_Sel) using the values present before the edge.
- Throughput: a new operation every cycle. No stall or valid signal.
- Result computation is purely combinational from A, B, ALU_Sel, so there is no internal state besides the output register.
- Opcodes (all operands unsigned; R = 9-bit result):
  - 0 ADD: R = {0,A} + {0,B}. Bit 8 = carry.
  - 1 SUB: R = ({0,A} - {0,B}) mod 512. Bit 8 = 1 when A < B (borrow).
  - 2 MUL: R = low 9 bits of the 16-bit product A*B.
  - 3 DIV: R = {0, A/B} (integer quotient). If B = 0, R = 9'h1FF; this is the only DIV case with bit 8 set.
  - 4 SHL: R = {A, 1'b0}[8:0], so bit 8 = A[7].
  - 5 SHR: R = {1'b0, A >> 1}.
  - 6 ROL: R = {1'b0, A[6:0], A[7]}.
  - 7 ROR: R = {1'b0, A[0], A[7:1]}.
  - 8 AND: R = {0, A & B}.
  - 9 OR: R = {0, A | B}.
  - A XOR: R = {0, A ^ B}.
  - B NOR: R = {0, ~(A | B)}.
  - C NAND: R = {0, ~(A & B)}.
  - D XNOR: R = {0, ~(A ^ B)}.
  - E GT: R = 1 if A > B, else 0.
  - F EQ: R = 1 if A == B, else 0.
- B is ignored for opcodes 4-7.
- Bit 8 is 0 for all logic and compare ops.
- Any X/Z on inputs: no requirement on the result.
- Reset asserted mid-stream: the output clears at once. The pipeline holds no other state, so nothing further is lost.

Decomposition:
- Package alu_pkg holds:
  - the 4-bit opcode enum/localparams OP_ADD..OP_EQ with the values listed above;
  - localparams DATA_W = 8 and RES_W = 9.
- Optional sub-module alu_comb: the combinational opcode decoder/datapath.
- The top module alu adds only the async-reset output register.

Test Plan:
- Reset: assert rst with non-zero inputs, no clock edges -> ALU_Result = 0 immediately. Release rst, then one edge with ADD 3+4 -> 7.
- ADD: 255+0 -> 255; 240+15 -> 255; 255+255 -> 510 (9'h1FE). Each value appears one cycle after it is applied.
- SUB/MUL/DIV:
  - SUB 10-3 -> 7; SUB 3-10 -> 9'h1F9.
  - MUL 16*16 -> 9'h100; MUL 255*255 -> 9'h001.
  - DIV 200/7 -> 28; DIV 5/0 -> 9'h1FF.
- Shift/rotate with A = 8'h81:
  - SHL -> 9'h102; SHR -> 9'h040.
  - ROL -> 9'h003; ROR -> 9'h0C0.
- Logic/compare with A = 8'hF0, B = 8'h3C:
  - AND 9'h030; OR 9'h0FC; XOR 9'h0CC.
  - NOR 9'h003; NAND 9'h0CF; XNOR 9'h033.
  - GT -> 1; EQ(5,5) -> 1; EQ(5,6) -> 0.
- Back-to-back: change the opcode every cycle over all 16 ops with random A/B -> each result matches the reference model delayed one cycle, with no bubbles.
